// File: rtl/ahb_matrix_input_stage.sv
// rtl/ahb_matrix_input_stage.sv - per-master AHB matrix input stage
// Holds an ungranted address phase, requests the arbiter and routes data-phase response.
module ahb_matrix_input_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSELS,
  input  logic [ADDR_W-1:0] HADDRS,
  input  logic [1:0]        HTRANSS,
  input  logic              HWRITES,
  input  logic [2:0]        HSIZES,
  input  logic [2:0]        HBURSTS,
  input  logic [3:0]        HPROTS,
  input  logic              HMASTLOCKS,
  input  logic              HREADYS,
  output logic              HREADYOUTS,
  output logic              HRESPS,
  input  logic              active_op,
  input  logic              hreadym_op,
  input  logic              readyout_op,
  input  logic              resp_op,
  output logic              req_op,
  output logic              sel_op,
  output logic [ADDR_W-1:0] addr_op,
  output logic [1:0]        trans_op,
  output logic              write_op,
  output logic [2:0]        size_op,
  output logic [2:0]        burst_op,
  output logic [3:0]        prot_op,
  output logic              mastlock_op
);

  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;
  localparam logic [2:0] BURST_INCR   = 3'b001;

  logic              pend_q, pend_d;
  logic              data_q, data_d;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        trans_q;
  logic              write_q;
  logic [2:0]        size_q;
  logic [2:0]        burst_q;
  logic [3:0]        prot_q;
  logic              lock_q;

  logic accept;
  logic issue;
  logic load;

  assign accept = HSELS & HREADYS & HTRANSS[1];
  assign issue  = active_op & hreadym_op;
  assign load   = accept & ~issue & ~pend_q;
  assign req_op = pend_q | accept;

  always_comb begin
    sel_op      = HSELS;
    addr_op     = HADDRS;
    trans_op    = HTRANSS;
    write_op    = HWRITES;
    size_op     = HSIZES;
    burst_op    = HBURSTS;
    prot_op     = HPROTS;
    mastlock_op = HMASTLOCKS;
    if (pend_q) begin
      sel_op      = 1'b1;
      addr_op     = addr_q;
      trans_op    = trans_q;
      write_op    = write_q;
      size_op     = size_q;
      burst_op    = burst_q;
      prot_op     = prot_q;
      mastlock_op = lock_q;
      // The interrupted burst resumes as an undefined-length INCR.
      if (trans_q == TRANS_SEQ) begin
        trans_op = TRANS_NONSEQ;
        burst_op = BURST_INCR;
      end
    end
  end

  // Only an issue of a transfer this port actually requested opens a data phase.
  always_comb begin
    pend_d = pend_q ? ~issue : load;
    data_d = data_q;
    if (issue & req_op & trans_op[1]) begin
      data_d = 1'b1;
    end else if (data_q & readyout_op) begin
      data_d = 1'b0;
    end
  end

  assign HREADYOUTS = pend_q ? 1'b0 : (data_q ? readyout_op : 1'b1);
  assign HRESPS     = data_q ? resp_op : 1'b0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend_q <= 1'b0;
      data_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      data_q <= data_d;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q  <= '0;
      trans_q <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
      burst_q <= '0;
      prot_q  <= '0;
      lock_q  <= 1'b0;
    end else if (load) begin
      addr_q  <= HADDRS;
      trans_q <= HTRANSS;
      write_q <= HWRITES;
      size_q  <= HSIZES;
      burst_q <= HBURSTS;
      prot_q  <= HPROTS;
      lock_q  <= HMASTLOCKS;
    end
  end

endmodule
